// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Handshake, payload and control bundle for pipe_stage_reg.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_reg_if #(
    parameter int XLEN   = 64,
    parameter int NFIELD = 4,
    parameter int CNT_W  = 16
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [NFIELD*XLEN-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [NFIELD*XLEN-1:0] out_data;
    logic                   stall;
    logic                   flush;
    logic [CNT_W-1:0]       bubble_cnt;
    logic                   bubble_clr;

    modport slave (
        input  in_valid, in_data, out_ready, stall, flush, bubble_clr,
        output in_ready, out_valid, out_data, bubble_cnt
    );

    modport master (
        output in_valid, in_data, out_ready, stall, flush, bubble_clr,
        input  in_ready, out_valid, out_data, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised pipeline register with 2-entry skid buffer,
//               stall, masked flush and saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int                XLEN      = 64,
    parameter int                NFIELD    = 4,
    parameter logic [NFIELD-1:0] HOLD_MASK = 4'b0001,
    parameter int                CNT_W     = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    pipe_stage_reg_if.slave  bus
);

    localparam int             c_dw      = NFIELD * XLEN;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_dw-1:0]   r_main;
    logic [c_dw-1:0]   r_skid;
    logic [c_dw-1:0]   w_main_nxt;
    logic [c_dw-1:0]   w_skid_nxt;
    logic [c_dw-1:0]   w_hold_bits;
    logic [CNT_W-1:0]  r_bubble;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;

    // Expand the per-field hold mask to a bit mask applied to main on flush.
    for (genvar i = 0; i < NFIELD; i++) begin : g_hold_mask
        assign w_hold_bits[i*XLEN +: XLEN] = HOLD_MASK[i] ? {XLEN{1'b1}} : {XLEN{1'b0}};
    end

    // Both decoded straight from state flops: no path from out_ready to in_ready.
    assign w_in_ready  = (r_state != S_TWO);
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_in_fire   = bus.in_valid & w_in_ready;
    assign w_out_fire  = w_out_valid & bus.out_ready & ~bus.stall;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (bus.flush) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = r_main & w_hold_bits;
            w_skid_nxt  = '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_nxt  = bus.in_data;
                        w_state_nxt = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = bus.in_data;
                    end else if (w_in_fire) begin
                        w_skid_nxt  = bus.in_data;
                        w_state_nxt = S_TWO;
                    end else if (w_out_fire) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_out_fire) begin
                        w_main_nxt  = r_skid;
                        w_state_nxt = S_ONE;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble <= '0;
        end else if (bus.bubble_clr) begin
            r_bubble <= '0;
        end else if (!w_out_valid && (r_bubble != c_cnt_max)) begin
            r_bubble <= r_bubble + c_cnt_one;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_data   = r_main;
    assign bus.bubble_cnt = r_bubble;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int c_xlen   = 64;
    localparam int c_nfield = 4;
    localparam int c_dw     = c_xlen * c_nfield;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pipe_stage_reg_if #(.XLEN(c_xlen), .NFIELD(c_nfield), .CNT_W(16)) b  ();
    pipe_stage_reg_if #(.XLEN(c_xlen), .NFIELD(c_nfield), .CNT_W(4))  b4 ();

    pipe_stage_reg #(.XLEN(c_xlen), .NFIELD(c_nfield), .HOLD_MASK(4'b0001), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    pipe_stage_reg #(.XLEN(c_xlen), .NFIELD(c_nfield), .HOLD_MASK(4'b0001), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [c_dw-1:0] mk(input logic [63:0] pc, input logic [63:0] a,
                                           input logic [63:0] bb, input logic [63:0] imm);
        return {imm, bb, a, pc};
    endfunction

    task automatic check(input string tag, input logic [c_dw-1:0] obs, input logic [c_dw-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [c_dw-1:0] beat_a, beat_b, beat_c;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0;
        b.stall = 1'b0; b.flush = 1'b0; b.bubble_clr = 1'b0;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b0;
        b4.stall = 1'b0; b4.flush = 1'b0; b4.bubble_clr = 1'b0;
        step();
        step();
        check("rst_out_valid", c_dw'(b.out_valid), '0);
        check("rst_out_data",  b.out_data, '0);
        check("rst_bubble",    c_dw'(b.bubble_cnt), '0);
        check("rst_in_ready",  c_dw'(b.in_ready), c_dw'(1));
        rst = 1'b0;

        // Idle: 10 edges with out_valid=0
        for (int i = 0; i < 10; i++) step();
        check("bubble_10", c_dw'(b.bubble_cnt), c_dw'(10));
        b.bubble_clr = 1'b1;
        step();
        check("bubble_clr", c_dw'(b.bubble_cnt), '0);
        b.bubble_clr = 1'b0;

        // Streaming at full rate
        b.out_ready = 1'b1;
        b.in_valid  = 1'b1;
        b.in_data   = mk(64'h100, 64'd1, 64'd2, 64'd3);
        step();
        check("stream_first_valid", c_dw'(b.out_valid), c_dw'(1));
        check("stream_beat0", b.out_data, mk(64'h100, 64'd1, 64'd2, 64'd3));
        for (int k = 1; k < 5; k++) begin
            b.in_data = mk(64'h100 + 64'(k), 64'(1 + k), 64'(2 + k), 64'(3 + k));
            step();
            check("stream_beat", b.out_data, mk(64'h100 + 64'(k), 64'(1 + k), 64'(2 + k), 64'(3 + k)));
            check("stream_in_ready", c_dw'(b.in_ready), c_dw'(1));
        end

        // Backpressure: A in main, B into skid, C held upstream
        beat_a = mk(64'h104, 64'd5, 64'd6, 64'd7);
        beat_b = mk(64'h110, 64'h11, 64'h12, 64'h13);
        beat_c = mk(64'h120, 64'h21, 64'h22, 64'h23);
        b.out_ready = 1'b0;
        b.in_data   = beat_b;
        step();
        check("bp_in_ready_low", c_dw'(b.in_ready), '0);
        check("bp_hold_a", b.out_data, beat_a);
        b.in_data = beat_c;
        step();
        check("bp_hold_a2", b.out_data, beat_a);
        step();
        check("bp_hold_a3", b.out_data, beat_a);
        check("bp_in_ready_low3", c_dw'(b.in_ready), '0);
        b.out_ready = 1'b1;
        step();
        check("bp_out_b", b.out_data, beat_b);
        check("bp_in_ready_back", c_dw'(b.in_ready), c_dw'(1));
        step();
        check("bp_out_c", b.out_data, beat_c);
        b.in_valid = 1'b0;
        step();
        check("bp_drain_empty", c_dw'(b.out_valid), '0);
        check("bp_drain_keep", b.out_data, beat_c);

        // Stall: A held at output, B fills skid
        beat_a = mk(64'h130, 64'h31, 64'h32, 64'h33);
        beat_b = mk(64'h140, 64'h41, 64'h42, 64'h43);
        b.in_valid = 1'b1;
        b.in_data  = beat_a;
        step();
        b.stall   = 1'b1;
        b.in_data = beat_b;
        step();
        check("stall_hold_a", b.out_data, beat_a);
        check("stall_in_ready", c_dw'(b.in_ready), '0);
        step();
        check("stall_hold_a2", b.out_data, beat_a);
        b.stall    = 1'b0;
        b.in_valid = 1'b0;
        step();
        check("stall_out_b", b.out_data, beat_b);
        step();
        check("stall_drain", c_dw'(b.out_valid), '0);

        // Flush with masking from state TWO
        b.out_ready = 1'b0;
        b.in_valid  = 1'b1;
        b.in_data   = mk(64'h200, 64'hAA, 64'hBB, 64'hCC);
        step();
        b.in_data = mk(64'h204, 64'd1, 64'd2, 64'd3);
        step();
        check("flush_pre_two", c_dw'(b.in_ready), '0);
        b.flush   = 1'b1;
        b.in_data = mk(64'h300, 64'd9, 64'd9, 64'd9);
        step();
        check("flush_valid", c_dw'(b.out_valid), '0);
        check("flush_mask", b.out_data, mk(64'h200, 64'd0, 64'd0, 64'd0));
        check("flush_in_ready", c_dw'(b.in_ready), c_dw'(1));
        check("flush_skid", dut.r_skid, '0);
        b.flush   = 1'b0;
        b.in_data = mk(64'h400, 64'd5, 64'd6, 64'd7);
        step();
        check("post_flush_load", b.out_data, mk(64'h400, 64'd5, 64'd6, 64'd7));

        // Flush beats stall
        b.in_valid  = 1'b0;
        b.out_ready = 1'b1;
        b.stall     = 1'b1;
        b.flush     = 1'b1;
        step();
        check("flush_stall_valid", c_dw'(b.out_valid), '0);
        check("flush_stall_mask", b.out_data, mk(64'h400, 64'd0, 64'd0, 64'd0));
        b.stall = 1'b0;
        b.flush = 1'b0;

        // Asynchronous reset mid-operation
        b.in_valid = 1'b1;
        b.in_data  = mk(64'h500, 64'd1, 64'd1, 64'd1);
        step();
        check("pre_rst_valid", c_dw'(b.out_valid), c_dw'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", c_dw'(b.out_valid), '0);
        check("async_rst_data", b.out_data, '0);
        b.in_valid = 1'b0;
        step();
        rst = 1'b0;

        // Saturation on the 4-bit counter instance
        for (int i = 0; i < 14; i++) step();
        check("sat_14", c_dw'(b4.bubble_cnt), c_dw'(14));
        step();
        check("sat_15", c_dw'(b4.bubble_cnt), c_dw'(15));
        for (int i = 0; i < 5; i++) step();
        check("sat_hold", c_dw'(b4.bubble_cnt), c_dw'(15));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
